// File: rtl/vdma_pkg.sv
// Shared definitions for the VDMA write-side line-buffer controller:
// FSM state encoding and small elaboration-time helpers.
package vdma_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Number of pixel lanes in one RAM word.
  function automatic int unsigned pack_of(input int unsigned wwidth,
                                          input int unsigned pix_width);
    return wwidth / pix_width;
  endfunction

  // Width of a lane index; a single-lane word still needs a 1-bit counter.
  function automatic int unsigned lane_bits(input int unsigned pack);
    return (pack > 1) ? $clog2(pack) : 1;
  endfunction

  function automatic int unsigned min_u(input int unsigned a,
                                        input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/vdma_pix_packer.sv
// Packs pixels into RAM words, lane 0 first. A word completes on the last
// lane or on end-of-frame; lanes not yet written are zero because the
// accumulator is cleared every time a word leaves.
module vdma_pix_packer
  import vdma_pkg::*;
#(
  parameter int unsigned PIX_WIDTH = 16,
  parameter int unsigned WWIDTH    = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 pix_valid,
  input  logic [PIX_WIDTH-1:0] pix_data,
  input  logic                 pix_eof,
  output logic                 word_valid,
  output logic [WWIDTH-1:0]    word_data
);

  localparam int unsigned PACK   = pack_of(WWIDTH, PIX_WIDTH);
  localparam int unsigned LANE_W = lane_bits(PACK);

  logic [LANE_W-1:0] lane;
  logic [WWIDTH-1:0] acc;
  logic [WWIDTH-1:0] lane_word;
  logic              last_lane;

  // Place the incoming pixel into its lane; every other lane is zero.
  for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
    assign lane_word[gi*PIX_WIDTH +: PIX_WIDTH] =
      (lane == LANE_W'(gi)) ? pix_data : '0;
  end

  assign last_lane  = (lane == LANE_W'(PACK - 1));
  assign word_valid = pix_valid && (last_lane || pix_eof);
  assign word_data  = acc | lane_word;

  // Lane counter and partial-word accumulator; a frame start drops any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= '0;
      acc  <= '0;
    end else if (clear) begin
      lane <= '0;
      acc  <= '0;
    end else if (pix_valid) begin
      if (last_lane || pix_eof) begin
        lane <= '0;
        acc  <= '0;
      end else begin
        lane <= lane + 1'b1;
        acc  <= word_data;
      end
    end
  end

endmodule

// File: rtl/vdma_wr_linebuf_ctrl.sv
// Write-side controller for the VDMA line-buffer RAM: frame FSM, RAM
// write/read pointers, occupancy counter, burst request and overflow flag.
module vdma_wr_linebuf_ctrl
  import vdma_pkg::*;
#(
  parameter int unsigned PIX_WIDTH  = 16,
  parameter int unsigned WWIDTH     = 64,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  data_valid,
  input  logic [PIX_WIDTH-1:0]  data,
  input  logic                  eof,
  input  logic                  rd_adv,
  output logic [WWIDTH-1:0]     wdata,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  burst_rdy,
  output logic [ADDR_WIDTH:0]   burst_words,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int unsigned  LW      = ADDR_WIDTH + 1;
  localparam int unsigned  DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] BURST_L = LW'(BURST_LEN);

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [ADDR_WIDTH-1:0] wptr;
  logic                  accept;
  logic                  word_valid;
  logic [WWIDTH-1:0]     word_data;
  logic                  honoured;
  logic                  full;
  logic                  do_write;
  logic                  drop;
  logic [LW-1:0]         level_next;
  logic                  burst_rdy_next;
  logic [LW-1:0]         burst_words_next;

  // Frame start takes priority, so a pixel in that cycle is never accepted.
  assign accept   = data_valid && (state == ST_FILL) && !frame_start;
  assign honoured = rd_adv && (level != '0);
  // A write still in flight counts against capacity.
  assign full     = (level + LW'(wen)) >= DEPTH_L;
  assign do_write = word_valid && !full;
  assign drop     = word_valid && full;

  vdma_pix_packer #(
    .PIX_WIDTH (PIX_WIDTH),
    .WWIDTH    (WWIDTH)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (frame_start),
    .pix_valid  (accept),
    .pix_data   (data),
    .pix_eof    (eof),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  // Next-state decode; the frame is done once drained with no write outstanding.
  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    if (frame_start) begin
      state_next = ST_FILL;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_IDLE;
        ST_FILL:  if (accept && eof) state_next = ST_FLUSH;
        ST_FLUSH: begin
          if ((level == '0) && !wen) begin
            state_next = ST_IDLE;
            frame_done = 1'b1;
          end
        end
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Occupancy and burst sizing, computed from the level after this cycle.
  always_comb begin
    level_next = level;
    if (frame_start) begin
      level_next = '0;
    end else begin
      case ({wen, honoured})
        2'b10:   level_next = level + 1'b1;
        2'b01:   level_next = level - 1'b1;
        default: level_next = level;
      endcase
    end
    burst_rdy_next = (level_next >= BURST_L) ||
                     ((state_next == ST_FLUSH) && (level_next != '0));
    burst_words_next = (state_next == ST_FLUSH) ?
                       LW'(min_u(32'(level_next), BURST_LEN)) : BURST_L;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // RAM write port, write pointer and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen      <= 1'b0;
      wdata    <= '0;
      waddr    <= '0;
      wptr     <= '0;
      overflow <= 1'b0;
    end else if (frame_start) begin
      wen      <= 1'b0;
      waddr    <= '0;
      wptr     <= '0;
      overflow <= 1'b0;
    end else begin
      wen <= do_write;
      if (do_write) begin
        wdata <= word_data;
        waddr <= wptr;
        wptr  <= wptr + 1'b1;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  // Read pointer advances only on reads the buffer can honour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           raddr <= '0;
    else if (frame_start) raddr <= '0;
    else if (honoured)    raddr <= raddr + 1'b1;
  end

  // Level counter and registered burst request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level       <= '0;
      burst_rdy   <= 1'b0;
      burst_words <= '0;
    end else begin
      level       <= level_next;
      burst_rdy   <= burst_rdy_next;
      burst_words <= burst_words_next;
    end
  end

endmodule

// File: tb/tb_vdma_wr_linebuf_ctrl.sv
// Directed testbench for vdma_wr_linebuf_ctrl with hand-computed expectations.
module tb_vdma_wr_linebuf_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        data_valid = 1'b0;
  logic [15:0] data = '0;
  logic        eof = 1'b0;
  logic        rd_adv = 1'b0;
  logic [63:0] wdata;
  logic [8:0]  waddr;
  logic        wen;
  logic [8:0]  raddr;
  logic [9:0]  level;
  logic        burst_rdy;
  logic [9:0]  burst_words;
  logic        frame_done;
  logic        overflow;

  int n_checks = 0;
  int n_fail = 0;

  logic [63:0] wr_data[$];
  logic [8:0]  wr_addr[$];
  int          max_level;
  logic        wrap_w, wrap_r, have_prev_w, follow_rd;
  logic [8:0]  prev_waddr, prev_raddr;

  always #5 clk = ~clk;

  vdma_wr_linebuf_ctrl #(
    .PIX_WIDTH(16), .WWIDTH(64), .ADDR_WIDTH(9), .BURST_LEN(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .data_valid(data_valid), .data(data), .eof(eof), .rd_adv(rd_adv),
    .wdata(wdata), .waddr(waddr), .wen(wen), .raddr(raddr),
    .level(level), .burst_rdy(burst_rdy), .burst_words(burst_words),
    .frame_done(frame_done), .overflow(overflow)
  );

  task automatic clear_log();
    wr_data.delete();
    wr_addr.delete();
    max_level   = 0;
    wrap_w      = 1'b0;
    wrap_r      = 1'b0;
    have_prev_w = 1'b0;
    prev_waddr  = '0;
    prev_raddr  = raddr;
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    if (follow_rd) rd_adv = wen;
    @(posedge clk);
    #1;
    if (wen) begin
      wr_data.push_back(wdata);
      wr_addr.push_back(waddr);
      if (have_prev_w && prev_waddr == 9'd511 && waddr == 9'd0) wrap_w = 1'b1;
      prev_waddr  = waddr;
      have_prev_w = 1'b1;
    end
    if (prev_raddr == 9'd511 && raddr == 9'd0) wrap_r = 1'b1;
    prev_raddr = raddr;
    if (int'(level) > max_level) max_level = int'(level);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic e);
    data_valid = 1'b1;
    data       = d;
    eof        = e;
    tick();
  endtask

  task automatic idle(input int n);
    data_valid = 1'b0;
    eof        = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_frame();
    data_valid  = 1'b0;
    eof         = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    clear_log();
  endtask

  initial begin
    follow_rd = 1'b0;
    clear_log();

    // Reset state
    tick();
    tick();
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_raddr", 64'(raddr), 64'd0);
    chk("rst_burst", 64'({burst_rdy, burst_words, overflow, frame_done}), 64'd0);
    rst_n = 1'b1;
    tick();
    $display("step: reset released");

    // 64 pixels, EOF on last, no reads
    start_frame();
    for (int i = 1; i <= 64; i++) push(16'(i), i == 64);
    idle(2);
    $display("step: 64-pixel frame, %0d writes", wr_data.size());
    chk("t1_wr_count", 64'(wr_data.size()), 64'd16);
    chk("t1_word0", wr_data[0], 64'h0004_0003_0002_0001);
    chk("t1_addr0", 64'(wr_addr[0]), 64'd0);
    chk("t1_word15", wr_data[15], 64'h0040_003F_003E_003D);
    chk("t1_level", 64'(level), 64'd16);
    chk("t1_burst_rdy", 64'(burst_rdy), 64'd1);
    chk("t1_burst_words", 64'(burst_words), 64'd16);

    // 6 pixels, partial last word, drain to frame done
    start_frame();
    for (int i = 1; i <= 6; i++) push(16'(i), i == 6);
    idle(2);
    $display("step: 6-pixel frame, %0d writes", wr_data.size());
    chk("t2_wr_count", 64'(wr_data.size()), 64'd2);
    chk("t2_word1", wr_data[1], 64'h0000_0000_0006_0005);
    chk("t2_addr1", 64'(wr_addr[1]), 64'd1);
    chk("t2_level", 64'(level), 64'd2);
    chk("t2_burst_words", 64'(burst_words), 64'd2);
    chk("t2_burst_rdy", 64'(burst_rdy), 64'd1);
    chk("t2_done_early", 64'(frame_done), 64'd0);
    rd_adv = 1'b1;
    tick();
    tick();
    rd_adv = 1'b0;
    chk("t2_frame_done", 64'(frame_done), 64'd1);
    chk("t2_level_drained", 64'(level), 64'd0);
    chk("t2_raddr", 64'(raddr), 64'd2);
    tick();
    chk("t2_done_pulse_end", 64'(frame_done), 64'd0);
    chk("t2_burst_rdy_idle", 64'(burst_rdy), 64'd0);
    clear_log();
    for (int i = 0; i < 4; i++) push(16'h7000 + 16'(i), 1'b0);
    idle(2);
    $display("step: pixels offered in idle");
    chk("t2_idle_writes", 64'(wr_data.size()), 64'd0);
    chk("t2_idle_level", 64'(level), 64'd0);

    // Fill to 512 words then 4 more pixels
    start_frame();
    for (int i = 0; i < 2052; i++) push(16'(i + 1), 1'b0);
    idle(2);
    $display("step: overfill, %0d writes", wr_data.size());
    chk("t3_wr_count", 64'(wr_data.size()), 64'd512);
    chk("t3_last_addr", 64'(wr_addr[511]), 64'd511);
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_level", 64'(level), 64'd512);
    chk("t3_burst_rdy", 64'(burst_rdy), 64'd1);
    start_frame();
    chk("t3_ovf_cleared", 64'(overflow), 64'd0);
    chk("t3_level_cleared", 64'(level), 64'd0);
    chk("t3_waddr_cleared", 64'(waddr), 64'd0);

    // Steady stream, reading every written word, 600 words
    follow_rd = 1'b1;
    for (int i = 0; i < 2400; i++) push(16'(i), 1'b0);
    data_valid = 1'b0;
    tick();
    follow_rd = 1'b0;
    rd_adv = 1'b0;
    tick();
    $display("step: steady stream, %0d writes", wr_data.size());
    chk("t4_wr_count", 64'(wr_data.size()), 64'd600);
    chk("t4_max_level", 64'(max_level), 64'd1);
    chk("t4_level", 64'(level), 64'd1);
    chk("t4_waddr_wrap", 64'(wrap_w), 64'd1);
    chk("t4_raddr_wrap", 64'(wrap_r), 64'd1);
    chk("t4_waddr", 64'(waddr), 64'd87);
    chk("t4_raddr", 64'(raddr), 64'd87);
    chk("t4_overflow", 64'(overflow), 64'd0);

    // Read at empty, then frame start over a partial word
    start_frame();
    chk("t5_raddr_start", 64'(raddr), 64'd0);
    rd_adv = 1'b1;
    tick();
    rd_adv = 1'b0;
    chk("t5_raddr_empty", 64'(raddr), 64'd0);
    chk("t5_level_empty", 64'(level), 64'd0);
    push(16'h0011, 1'b0);
    push(16'h0022, 1'b0);
    push(16'h0033, 1'b0);
    frame_start = 1'b1;
    data_valid  = 1'b1;
    data        = 16'h0044;
    tick();
    frame_start = 1'b0;
    clear_log();
    push(16'hAAAA, 1'b1);
    $display("step: restart mid-word, wdata 0x%0h", wdata);
    chk("t5_wen", 64'(wen), 64'd1);
    chk("t5_wdata", wdata, 64'h0000_0000_0000_AAAA);
    chk("t5_waddr", 64'(waddr), 64'd0);
    idle(2);
    chk("t5_wr_count", 64'(wr_data.size()), 64'd1);

    // Asynchronous reset in the middle of a burst
    start_frame();
    for (int i = 0; i < 80; i++) push(16'(i + 1), 1'b0);
    chk("t6_level_pre", 64'(level), 64'd19);
    chk("t6_burst_pre", 64'(burst_rdy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("step: async reset asserted");
    chk("t6_wen", 64'(wen), 64'd0);
    chk("t6_wdata", wdata, 64'd0);
    chk("t6_waddr", 64'(waddr), 64'd0);
    chk("t6_level", 64'(level), 64'd0);
    chk("t6_flags", 64'({burst_rdy, burst_words, frame_done, overflow, raddr}), 64'd0);
    data_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    clear_log();
    for (int i = 0; i < 8; i++) push(16'h5000 + 16'(i), 1'b0);
    idle(2);
    $display("step: pixels after reset release");
    chk("t6_idle_writes", 64'(wr_data.size()), 64'd0);
    chk("t6_idle_level", 64'(level), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
